// File: rtl/serial_in_rx_if.sv
// Bundle of the serial receiver's line, handshake and status signals.
// slave = receiver side, master = the link/consumer side driving it.
interface serial_in_rx_if #(
    parameter int MSG_W = 4,
    parameter int GAP_W = 4
);
    logic             EN;
    logic             SER_SEND;
    logic             SER_DATA;
    logic             MSG_ACK;
    logic             OVR_CLR;
    logic [MSG_W-1:0] MSG_OUT;
    logic             MSG_VALID;
    logic [GAP_W-1:0] GAP_OUT;
    logic             FRAME_ERR;
    logic             OVERRUN;

    modport master (
        output EN, SER_SEND, SER_DATA, MSG_ACK, OVR_CLR,
        input  MSG_OUT, MSG_VALID, GAP_OUT, FRAME_ERR, OVERRUN
    );

    modport slave (
        input  EN, SER_SEND, SER_DATA, MSG_ACK, OVR_CLR,
        output MSG_OUT, MSG_VALID, GAP_OUT, FRAME_ERR, OVERRUN
    );
endinterface

// File: rtl/serial_in_rx.sv
// Serial link receiver: deserialises strobe-framed LSB-first words into a
// one-deep valid/ack register, with framing-error, overrun and idle-gap reporting.
module serial_in_rx #(
    parameter int MSG_W = 4,
    parameter int GAP_W = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    serial_in_rx_if.slave bus
);
    localparam int CNT_W = (MSG_W > 1) ? $clog2(MSG_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(MSG_W - 1);

    typedef enum logic [2:0] {WAIT_LOW, IDLE, RECV, STOP, ERR} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] bit_cnt;
    logic [MSG_W-1:0] shreg;
    logic [GAP_W-1:0] gap_cnt, gap_hold;
    logic [MSG_W-1:0] msg_q;
    logic [GAP_W-1:0] gap_q;
    logic             valid_q, ferr_q, ovr_q;
    logic             start, capture, commit, ferr, gap_inc, gap_clr;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= WAIT_LOW;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        capture  = 1'b0;
        commit   = 1'b0;
        ferr     = 1'b0;
        gap_inc  = 1'b0;
        gap_clr  = 1'b0;
        if (!bus.EN) begin
            state_nx = WAIT_LOW;
        end else begin
            case (state)
                // Never lock onto a frame already in progress.
                WAIT_LOW: if (!bus.SER_SEND) state_nx = IDLE;
                IDLE: begin
                    if (bus.SER_SEND) begin
                        start    = 1'b1;
                        capture  = 1'b1;
                        gap_clr  = 1'b1;
                        state_nx = (MSG_W == 1) ? STOP : RECV;
                    end else begin
                        gap_inc = 1'b1;
                    end
                end
                RECV: begin
                    if (bus.SER_SEND) begin
                        capture = 1'b1;
                        if (bit_cnt == LAST_BIT) state_nx = STOP;
                    end else begin
                        ferr     = 1'b1;
                        gap_clr  = 1'b1;
                        state_nx = IDLE;
                    end
                end
                STOP: begin
                    if (bus.SER_SEND) begin
                        ferr     = 1'b1;
                        state_nx = ERR;
                    end else begin
                        commit   = 1'b1;
                        gap_inc  = 1'b1;
                        state_nx = IDLE;
                    end
                end
                ERR:      if (!bus.SER_SEND) state_nx = IDLE;
                default:  state_nx = WAIT_LOW;
            endcase
        end
    end

    // bit_cnt indexes the bit being captured; it rests at 0 outside a frame.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (capture) begin
            shreg[bit_cnt] <= bus.SER_DATA;
            bit_cnt        <= bit_cnt + CNT_W'(1);
        end else begin
            bit_cnt <= '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            gap_cnt  <= '0;
            gap_hold <= '0;
        end else begin
            if (start) gap_hold <= gap_cnt;
            if (!bus.EN || gap_clr)            gap_cnt <= '0;
            else if (gap_inc && gap_cnt != '1) gap_cnt <= gap_cnt + GAP_W'(1);
        end
    end

    // A commit may reuse the slot in the same cycle the consumer acks it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            msg_q   <= '0;
            gap_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            ferr_q <= ferr;
            if (commit && (!valid_q || bus.MSG_ACK)) begin
                msg_q   <= shreg;
                gap_q   <= gap_hold;
                valid_q <= 1'b1;
            end else if (valid_q && bus.MSG_ACK) begin
                valid_q <= 1'b0;
            end
            if (commit && valid_q && !bus.MSG_ACK) ovr_q <= 1'b1;
            else if (bus.OVR_CLR)                  ovr_q <= 1'b0;
        end
    end

    assign bus.MSG_OUT   = msg_q;
    assign bus.GAP_OUT   = gap_q;
    assign bus.MSG_VALID = valid_q;
    assign bus.FRAME_ERR = ferr_q;
    assign bus.OVERRUN   = ovr_q;
endmodule

// File: tb/tb_serial_in_rx.sv
// Directed plus randomized bench for serial_in_rx; expectations come from a
// run-length model of the serial line kept alongside the stimulus.
module tb_serial_in_rx;
    localparam int MSG_W = 4;
    localparam int GAP_W = 4;
    localparam int GMAX  = (1 << GAP_W) - 1;

    logic CLK;
    logic RST_N;
    serial_in_rx_if #(.MSG_W(MSG_W), .GAP_W(GAP_W)) bus ();

    serial_in_rx #(.MSG_W(MSG_W), .GAP_W(GAP_W)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    bit en_v, ack_v, clr_v;

    // Model state: armed = low seen since reset/enable; hi = length of current high run.
    bit m_armed;
    int m_hi, m_gap, m_hold, m_bits;
    int m_msg, m_gapout;
    bit m_valid, m_ovr, m_ferr;

    function automatic void model_reset();
        m_armed = 0; m_hi = 0; m_gap = 0; m_hold = 0; m_bits = 0;
        m_msg = 0; m_gapout = 0; m_valid = 0; m_ovr = 0; m_ferr = 0;
    endfunction

    function automatic void model_edge(bit send, bit data, bit en, bit ack, bit clr);
        bit commit, ovr_set;
        commit = 0;
        m_ferr = 0;
        if (!en) begin
            m_armed = 0; m_hi = 0; m_gap = 0;
        end else if (!m_armed) begin
            if (!send) m_armed = 1;
        end else if (send) begin
            m_hi++;
            if (m_hi == 1) begin m_hold = m_gap; m_gap = 0; m_bits = 0; end
            if (m_hi <= MSG_W) m_bits |= int'(data) << (m_hi - 1);
            if (m_hi == MSG_W + 1) m_ferr = 1;
        end else begin
            if (m_hi == 0) begin
                if (m_gap < GMAX) m_gap++;
            end else if (m_hi < MSG_W) begin
                m_ferr = 1; m_gap = 0;
            end else if (m_hi == MSG_W) begin
                commit = 1; m_gap = 1;   // the stop cycle itself is idle time
            end
            m_hi = 0;
        end
        ovr_set = commit && m_valid && !ack;
        if (commit && (!m_valid || ack)) begin
            m_msg = m_bits; m_gapout = m_hold; m_valid = 1;
        end else if (m_valid && ack) begin
            m_valid = 0;
        end
        if (ovr_set) m_ovr = 1;
        else if (clr) m_ovr = 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_msg"},   32'(bus.MSG_OUT),   32'(m_msg));
        chk({tag, "_valid"}, 32'(bus.MSG_VALID), 32'(m_valid));
        chk({tag, "_gap"},   32'(bus.GAP_OUT),   32'(m_gapout));
        chk({tag, "_ferr"},  32'(bus.FRAME_ERR), 32'(m_ferr));
        chk({tag, "_ovr"},   32'(bus.OVERRUN),   32'(m_ovr));
    endtask

    task automatic step(input bit send, input bit data);
        bus.SER_SEND = send;
        bus.SER_DATA = data;
        bus.EN       = en_v;
        bus.MSG_ACK  = ack_v;
        bus.OVR_CLR  = clr_v;
        @(posedge CLK);
        model_edge(send, data, en_v, ack_v, clr_v);
        #1;
        check_all("step");
    endtask

    // nhi high cycles carrying val LSB first, then nlow low cycles (first is the stop).
    task automatic frame(input int val, input int nhi, input bit ack_stop, input int nlow);
        for (int i = 0; i < nhi; i++)
            step(1'b1, (i < MSG_W) ? val[i] : 1'($urandom));
        ack_v = ack_stop;
        step(1'b0, 1'($urandom));
        ack_v = 1'b0;
        for (int i = 1; i < nlow; i++) step(1'b0, 1'($urandom));
    endtask

    task automatic do_reset(input string tag);
        RST_N = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        repeat (2) @(posedge CLK);
        #1;
        check_all(tag);
        RST_N = 1'b1;
    endtask

    task automatic ack_once();
        ack_v = 1'b1;
        step(1'b0, 1'b0);
        ack_v = 1'b0;
    endtask

    initial begin
        int v1, v2, v3;
        en_v = 1; ack_v = 0; clr_v = 0;
        bus.EN = 1; bus.SER_SEND = 0; bus.SER_DATA = 0; bus.MSG_ACK = 0; bus.OVR_CLR = 0;
        RST_N = 1'b0;
        #2;
        do_reset("rst0");

        // Reset mid-frame, then release with strobe high: nothing captured.
        step(0, 0);
        frame(4'h6, MSG_W, 0, 2);
        step(1, 1); step(1, 0);
        do_reset("rst_mid");
        for (int i = 0; i < 6; i++) step(1'b1, 1'($urandom));
        chk("rst_nocap_valid", 32'(bus.MSG_VALID), 32'd0);
        step(0, 0);
        frame(4'h9, MSG_W, 0, 2);
        chk("rst_after_msg", 32'(bus.MSG_OUT), 32'h9);
        ack_once();

        // Basic frame 1,0,1,1 and hold until acked.
        frame(4'hD, MSG_W, 0, 3);
        chk("t2_msg", 32'(bus.MSG_OUT), 32'hD);
        chk("t2_valid", 32'(bus.MSG_VALID), 32'd1);
        ack_once();
        chk("t2_acked", 32'(bus.MSG_VALID), 32'd0);

        // Gap reporting and saturation.
        v1 = $urandom_range(0, 15); v2 = $urandom_range(0, 15); v3 = $urandom_range(0, 15);
        frame(v1, MSG_W, 1, 6);
        frame(v2, MSG_W, 1, 20);
        chk("t3_gap6", 32'(bus.GAP_OUT), 32'd6);
        frame(v3, MSG_W, 1, 3);
        chk("t3_gap15", 32'(bus.GAP_OUT), 32'd15);
        chk("t3_msg", 32'(bus.MSG_OUT), 32'(v3));
        ack_once();

        // Short and long frames are rejected; next good frame accepted.
        frame($urandom, 2, 0, 3);
        chk("t4_short_valid", 32'(bus.MSG_VALID), 32'd0);
        frame($urandom, 5, 0, 3);
        chk("t4_long_valid", 32'(bus.MSG_VALID), 32'd0);
        frame(4'h3, MSG_W, 0, 3);
        chk("t4_good_msg", 32'(bus.MSG_OUT), 32'h3);
        ack_once();

        // Overrun, same-edge ack reuse, overrun clear.
        frame(4'hA, MSG_W, 0, 3);
        frame(4'h5, MSG_W, 0, 3);
        chk("t5_ovr", 32'(bus.OVERRUN), 32'd1);
        chk("t5_kept", 32'(bus.MSG_OUT), 32'hA);
        frame(4'h5, MSG_W, 1, 3);
        chk("t5_reuse_msg", 32'(bus.MSG_OUT), 32'h5);
        chk("t5_reuse_valid", 32'(bus.MSG_VALID), 32'd1);
        clr_v = 1; step(0, 0); clr_v = 0;
        chk("t5_clr", 32'(bus.OVERRUN), 32'd0);
        ack_once();

        // Enable dropped mid-frame, raised while strobe high.
        step(1, 1); step(1, 0);
        en_v = 0;
        step(1, 1); step(0, 0); step(1, 0);
        en_v = 1;
        step(1, 1); step(1, 1); step(1, 0);
        chk("t6_novalid", 32'(bus.MSG_VALID), 32'd0);
        step(0, 0); step(0, 0);
        frame(4'h9, MSG_W, 0, 3);
        chk("t6_msg", 32'(bus.MSG_OUT), 32'h9);
        ack_once();

        // Randomized runs with random ack, clear and enable traffic.
        for (int k = 0; k < 60; k++) begin
            int nhi, nlow;
            nhi  = $urandom_range(1, 6);
            nlow = $urandom_range(1, 18);
            for (int i = 0; i < nhi + nlow; i++) begin
                ack_v = ($urandom_range(0, 3) == 0);
                clr_v = ($urandom_range(0, 7) == 0);
                en_v  = ($urandom_range(0, 40) != 0);
                step(i < nhi, 1'($urandom));
            end
        end
        en_v = 1; ack_v = 0; clr_v = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
